minv_result_reader: RTL and testbench

- Reader side of the modular-inverse result flag.
- On `start`, samples `minv_flag` to decide which register bank holds minv: 0 selects regx1, 1 selects regx2.
- Reads that bank word by word through a synchronous 1-cycle-latency read port.
- Streams the words to the host interface over a valid/ready handshake, with a last-word marker and a done pulse.

---
 rtl/minv_result_reader_if.sv | 29 ++
 rtl/minv_result_reader.sv | 112 +++++++++++
 tb/tb_minv_result_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/minv_result_reader_if.sv
// Read-port and output-stream bundle for the minv result reader.
// master = reader (drives the read strobe and the output stream), slave = regfile/host side.
interface minv_result_reader_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 3
);
    logic              rd_en;
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (
        output rd_en, rd_sel, rd_addr,
        input  rd_data,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_sel, rd_addr,
        output rd_data,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/minv_result_reader.sv
// Streams the modular-inverse result from the bank chosen by minv_flag to the host.
// Define MINV_RD_MSW_FIRST_EN to stream most-significant word first.
//
// state   | meaning
// IDLE    | waiting for start; flag sampled here only
// ISSUE   | rd_en high for one cycle at rd_addr = widx
// CAPTURE | read data returns; loaded into out_data
// SEND    | out_valid held until out_ready
// FIN     | done pulse, busy still high
module minv_result_reader #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  minv_flag,
    output logic                  busy,
    output logic                  done,
    minv_result_reader_if.master  bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, FIN} state_t;

`ifdef MINV_RD_MSW_FIRST_EN
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(NWORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = '0;
`else
    localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NWORDS - 1);
`endif

    state_t            state;
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] widx_nxt;
    logic              sel_q;
    logic [WORD_W-1:0] data_q;

`ifdef MINV_RD_MSW_FIRST_EN
    assign widx_nxt = widx - 1'b1;
`else
    assign widx_nxt = widx + 1'b1;
`endif

    assign bus.out_data = data_q;

    // Outputs are registered on the transition into the state that owns them,
    // so rd_en is high exactly during ISSUE and done exactly during FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            widx          <= '0;
            sel_q         <= 1'b0;
            data_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.rd_sel    <= 1'b0;
            bus.rd_addr   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q       <= minv_flag;
                        widx        <= FIRST_IDX;
                        busy        <= 1'b1;
                        bus.rd_en   <= 1'b1;
                        bus.rd_sel  <= minv_flag;
                        bus.rd_addr <= FIRST_IDX;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.rd_en <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    data_q        <= bus.rd_data;
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= (widx == LAST_IDX);
                    state         <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (bus.out_last) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            widx        <= widx_nxt;
                            bus.rd_en   <= 1'b1;
                            bus.rd_sel  <= sel_q;
                            bus.rd_addr <= widx_nxt;
                            state       <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minv_result_reader.sv
// Randomised bench for minv_result_reader: regfile model plus an order/timing reference.
module tb_minv_result_reader;
    localparam int WORD_W = 32;
    localparam int NWORDS = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic minv_flag = 1'b0;
    logic busy;
    logic done;

    minv_result_reader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    minv_result_reader #(.WORD_W(WORD_W), .NWORDS(NWORDS), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .minv_flag (minv_flag),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] bank [2][NWORDS];

    always @(posedge clk)
        if (bus.rd_en) bus.rd_data <= bank[bus.rd_sel][bus.rd_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // k-th word of the stream -> register address
    function automatic int addr_of(input int k);
`ifdef MINV_RD_MSW_FIRST_EN
        return NWORDS - 1 - k;
`else
        return k;
`endif
    endfunction

    // cycle 0 = edge that accepts start; cyc is the cycle seen after edge cyc-1
    task automatic run_op(input bit flag, input int stall_word, input int stall_len,
                          input int ready_pct, input int late_start, input int flip_cyc,
                          input int rst_word, input int exp_done);
        int cyc = 1;
        int n_rd = 0;
        int n_hs = 0;
        int stall_cnt = 0;
        int last_hs = -10;
        @(negedge clk);
        start = 1'b1;
        minv_flag = flag;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        forever begin
            if (rst_word >= 0 && n_hs == rst_word && bus.out_valid) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_valid", bus.out_valid, 0);
                check("rst_rd_en", bus.rd_en, 0);
                check("rst_done", done, 0);
                check("rst_data", bus.out_data, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", done, 0);
                end
                rst_n = 1'b1;
                return;
            end
            check("busy", busy, 1);
            if (bus.rd_en) begin
                check("rd_sel", bus.rd_sel, flag);
                check("rd_addr", bus.rd_addr, addr_of(n_rd));
                n_rd++;
            end
            if (bus.out_valid) begin
                if (n_hs >= NWORDS) check("extra_word", n_hs, NWORDS - 1);
                else begin
                    check("out_data", bus.out_data, bank[flag][addr_of(n_hs)]);
                    check("out_last", bus.out_last, n_hs == NWORDS - 1);
                end
            end
            if (done) begin
                check("done_cyc", cyc, last_hs + 1);
                if (exp_done > 0) check("done_abs", cyc, exp_done);
                check("done_words", n_hs, NWORDS);
                start = (cyc == late_start);
                @(negedge clk);
                start = 1'b0;
                check("busy_after", busy, 0);
                check("done_pulse", done, 0);
                check("hold_data", bus.out_data, bank[flag][addr_of(NWORDS - 1)]);
                return;
            end
            if (cyc == flip_cyc) minv_flag = ~flag;
            start = (cyc == late_start);
            if (bus.out_valid && n_hs == stall_word && stall_cnt < stall_len) begin
                bus.out_ready = 1'b0;
                stall_cnt++;
                check("stall_no_rd", bus.rd_en, 0);
            end else begin
                bus.out_ready = ($urandom_range(99) < ready_pct);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_hs++;
                last_hs = cyc;
            end
            if (cyc > 400) begin
                check("timeout", cyc, 0);
                start = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            bank[0][i] = 32'h1000_0000 + i;
            bank[1][i] = 32'hA5A5_0000 + i;
        end
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", bus.rd_en, 0);
        check("reset_rd_sel", bus.rd_sel, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_valid", bus.out_valid, 0);
        check("reset_last", bus.out_last, 0);
        check("reset_data", bus.out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic regx1 read, start offered in the FIN cycle must be ignored
        run_op(1'b0, -1, 0, 100, 25, -1, -1, 25);
        // regx2 with flag flipped mid-operation
        run_op(1'b1, -1, 0, 100, -1, 5, -1, 25);
        // backpressure on word 3
        run_op(1'b0, 3, 4, 100, -1, -1, -1, 29);
        // second start while busy
        run_op(1'b1, -1, 0, 100, 10, -1, -1, 25);
        // reset during word 5, then a clean restart
        run_op(1'b0, -1, 0, 100, -1, -1, 5, 0);
        run_op(1'b0, -1, 0, 100, -1, -1, -1, 25);

        for (int t = 0; t < 8; t++) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NWORDS; i++) bank[b][i] = $urandom;
            run_op(1'($urandom_range(1)), int'($urandom_range(NWORDS - 1)),
                   int'($urandom_range(5)), int'($urandom_range(100, 30)),
                   int'($urandom_range(40, 2)), int'($urandom_range(30, 2)), -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
